// File: rtl/n1_pbus_prefetch.sv
// Instruction prefetch for the N1 program bus: pipelined Wishbone reads into a DEPTH-entry FIFO feeding the IR.
// Latency: redirect -> strobe next cycle; ack -> word valid next cycle. Backpressure: credits on FIFO room and outstanding reads.
module n1_pbus_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 14
) (
    input  logic          clk_i,
    input  logic          sync_rst_i,
    output logic          pbus_cyc_o,
    output logic          pbus_stb_o,
    output logic [AW-1:0] pbus_adr_o,
    input  logic          pbus_ack_i,
    input  logic          pbus_stall_i,
    input  logic [15:0]   pbus_dat_i,
    input  logic          fc2pf_redir_i,
    input  logic [AW-1:0] fc2pf_redir_adr_i,
    output logic          pf2ir_vld_o,
    output logic [15:0]   pf2ir_dat_o,
    output logic [AW-1:0] pf2ir_adr_o,
    input  logic          ir2pf_rdy_i,
    output logic          pf2fc_empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt_i, cnt_v, cnt_c;
    logic [CW-1:0] i_eff, v_eff;
    logic [CW:0]   occ;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [15:0]   mem_dat [DEPTH];
    logic [AW-1:0] mem_adr [DEPTH];
    logic [AW-1:0] fetch_adr, push_adr;
    logic          credit_ok, accept, ack_live, ack_valid, pop;

    always_comb begin
        state_nxt  = state;
        occ        = {1'b0, cnt_c} + {1'b0, cnt_v};
        credit_ok  = (occ < (CW+1)'(DEPTH)) && (cnt_i < CW'(DEPTH));
        pbus_stb_o = 1'b0;
        if (fc2pf_redir_i)
            state_nxt = RUN;
        if (state == RUN && credit_ok && !fc2pf_redir_i)
            pbus_stb_o = 1'b1;
        accept = pbus_stb_o && !pbus_stall_i;
        // A zero-wait slave acks the very request being accepted, so count it as outstanding already.
        i_eff     = cnt_i + CW'(accept);
        v_eff     = cnt_v + CW'(accept);
        ack_live  = pbus_ack_i && (i_eff != '0);
        ack_valid = ack_live && (i_eff == v_eff) && !fc2pf_redir_i;
        pop       = (cnt_c != '0) && ir2pf_rdy_i;
    end

    assign pbus_cyc_o    = pbus_stb_o || (cnt_i != '0);
    assign pbus_adr_o    = fetch_adr;
    assign pf2ir_vld_o   = (cnt_c != '0);
    assign pf2fc_empty_o = (cnt_c == '0);
    assign pf2ir_dat_o   = mem_dat[rd_ptr];
    assign pf2ir_adr_o   = mem_adr[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state     <= IDLE;
            cnt_i     <= '0;
            cnt_v     <= '0;
            cnt_c     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fetch_adr <= '0;
            push_adr  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_dat[k] <= '0;
                mem_adr[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt_i <= i_eff - CW'(ack_live);
            if (fc2pf_redir_i) begin
                // Everything in flight becomes stale; only I keeps tracking it until the acks drain.
                cnt_v     <= '0;
                cnt_c     <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                fetch_adr <= fc2pf_redir_adr_i;
                push_adr  <= fc2pf_redir_adr_i;
            end else begin
                cnt_v <= v_eff - CW'(ack_valid);
                cnt_c <= cnt_c + CW'(ack_valid) - CW'(pop);
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (accept)
                    fetch_adr <= fetch_adr + 1'b1;
                if (ack_valid) begin
                    mem_dat[wr_ptr] <= pbus_dat_i;
                    mem_adr[wr_ptr] <= push_adr;
                    wr_ptr          <= wr_ptr + 1'b1;
                    push_adr        <= push_adr + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/n1_pbus_prefetch.md
# n1_pbus_prefetch

Instruction prefetch unit for the N1 program bus. It issues pipelined Wishbone read cycles at sequential word addresses and buffers the returned instruction words in a small FIFO. It presents those words to the instruction register through a valid/ready handshake. On a change of flow from flow control it flushes all buffered and in-flight words and restarts fetching at the new address.

## Interface
Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, 2..8
- AW, 14, word address width; matches the direct absolute address width

Ports:
- clk_i  in  1  module clock
- sync_rst_i  in  1  synchronous reset, active high; the block has one clock and no asynchronous reset
- pbus_cyc_o  out  1  Wishbone cycle
- pbus_stb_o  out  1  Wishbone strobe (pipelined mode)
- pbus_adr_o  out  AW  word fetch address
- pbus_ack_i  in  1  read acknowledge
- pbus_stall_i  in  1  slave stall
- pbus_dat_i  in  16  read data
- fc2pf_redir_i  in  1  change of flow: flush and restart
- fc2pf_redir_adr_i  in  AW  restart address
- pf2ir_vld_o  out  1  instruction word available
- pf2ir_dat_o  out  16  instruction word at FIFO head
- pf2ir_adr_o  out  AW  address of the head word
- ir2pf_rdy_i  in  1  IR accepts the word
- pf2fc_empty_o  out  1  FIFO empty

## Operation
- States:
  - IDLE: entered on reset; no fetching.
  - RUN: entered on any fc2pf_redir_i; there is no exit except reset.
- Counters:
  - I counts total unacknowledged requests, range 0..DEPTH.
  - V counts valid unacknowledged requests, V ≤ I.
  - C counts FIFO occupancy, range 0..DEPTH.
- Credit: credit_ok = (C + V) < DEPTH and I < DEPTH.
- Strobe: pbus_stb_o = (state==RUN) & credit_ok & !fc2pf_redir_i. This is combinational.
- Cycle: pbus_cyc_o = pbus_stb_o | (I != 0).
- Accept = stb & !stall. On accept:
  - I+1 and V+1.
  - pbus_adr_o increments by 1 modulo 2^AW; wrap from all-ones to 0 is silent.
- Ack handling:
  - Ack with I > V is stale: the data is dropped and only I is decremented.
  - Ack with I == V > 0 is valid: the word is pushed to the FIFO with its address, then I-1 and V-1.
  - Ack with I == 0 is a protocol violation and is ignored.
- Pop happens on pf2ir_vld_o & ir2pf_rdy_i. The FIFO head advances.
- Redirect (fc2pf_redir_i), evaluated in that cycle:
  - The FIFO is cleared (C:=0) and V:=0.
  - I := I - ack. No accept occurs in this cycle because stb is low.
  - pbus_adr_o and the next push address both load fc2pf_redir_adr_i.
  - A pop handshake in the same cycle still completes for the IR; the flush applies afterwards.
  - A valid ack in the same cycle is discarded.
- Simultaneous push and pop: C is unchanged. Overflow cannot occur because of credit_ok.
- pf2ir_vld_o = (C != 0). pf2fc_empty_o = (C == 0).
- Reset values:
  - State IDLE; I, V, C all 0.
  - pbus_adr_o = 0; pbus_cyc_o = 0; pbus_stb_o = 0.
  - pf2ir_vld_o = 0; pf2ir_dat_o = 0; pf2ir_adr_o = 0; pf2fc_empty_o = 1.
- Reset mid-operation: all state is cleared in the next cycle and no further stb is driven. Late acks from the aborted cycle arrive with I==0 and are ignored.

## Timing
- Redirect sampled at edge 0: pbus_stb_o is high in cycle 1 with pbus_adr_o = redir address.
- Zero-wait slave (ack in the same cycle as accept, data registered into the FIFO): pf2ir_vld_o rises in cycle 2. The general rule is ack in cycle n gives vld in cycle n+1.
- Sustained throughput is 1 word/cycle when the slave has no stall and a registered ack, given DEPTH ≥ 2 plus slave latency.
- pf2ir_dat_o and pf2ir_adr_o are stable while vld & !rdy. They change only after a pop, a flush or a reset.
- The only combinational input-to-output paths are fc2pf_redir_i → pbus_stb_o/pbus_cyc_o and pbus_stall_i → none.

## Test plan
- Reset, then redirect to 0x0100 with zero-wait ack and rdy=1 → stb addresses 0x0100, 0x0101, …; IR receives data in order, vld first high in cycle 2, then 1 word/cycle.
- rdy=0 after redirect, DEPTH=4 → exactly 4 requests accepted; stb then stays low with C=4; a single rdy pulse → one pop and exactly one new request.
- Slave latency 3 cycles, redirect to 0x0200 with 3 requests in flight → 3 stale acks dropped; the first word delivered has pf2ir_adr_o=0x0200.
- pbus_stall_i held high for 5 cycles → pbus_adr_o holds and I is unchanged; the address advances only on the cycle stall drops.
- Redirect to 0x3FFE with AW=14 → fetched addresses 0x3FFE, 0x3FFF, 0x0000.
- sync_rst_i asserted with I=2 and C=3 → next cycle all outputs are at reset values; subsequent acks are ignored and vld stays 0 until a new redirect.
